// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Data-length encodings carried on tlen
  localparam logic [1:0] TLEN_5 = 2'b00;
  localparam logic [1:0] TLEN_6 = 2'b01;
  localparam logic [1:0] TLEN_7 = 2'b10;
  localparam logic [1:0] TLEN_8 = 2'b11;

  // Oversampling ratio and the tick index of the bit centre
  localparam int OVS = 16;
  localparam int MID = 8;

  // Number of data bits in a frame for a given tlen code
  function automatic logic [3:0] data_bits(input logic [1:0] len);
    logic [3:0] n;
    case (len)
      TLEN_5:  n = 4'd5;
      TLEN_6:  n = 4'd6;
      TLEN_7:  n = 4'd7;
      TLEN_8:  n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word fall-through FIFO holding received bytes.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DATA_W-1:0] last_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle
  assign do_push = wr_en && (!full || do_pop);
  // Head is visible while data is present; otherwise the last popped byte is held
  assign rdata   = empty ? last_q : mem[rptr[AW-1:0]];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer and held-output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr   <= rptr + PTR_ONE;
        last_q <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/recv.sv
// UART receiver: 16x oversampled deserialiser feeding an RX FIFO.
// Frame is one start bit, 5..8 data bits LSB first, one stop bit, no parity.
module recv
  import uart_pkg::*;
#(
  parameter int BAUD_DIV0  = 54,
  parameter int BAUD_DIV1  = 651,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bclk_mode,
  input  logic [1:0] tlen,
  input  logic       rx_in,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rdata,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_MAX = (BAUD_DIV0 > BAUD_DIV1) ? BAUD_DIV0 : BAUD_DIV1;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_LAST0 = DIV_W'(BAUD_DIV0 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST1 = DIV_W'(BAUD_DIV1 - 1);
  localparam logic [3:0]       SCNT_MID  = 4'(MID - 1);
  localparam logic [3:0]       SCNT_END  = 4'(OVS - 1);

  logic             sync1;
  logic             rx_s;
  logic             rx_prev;
  logic             fall;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic             mode_q;
  logic             tick;

  rx_state_e        state;
  logic [3:0]       scnt;
  logic [2:0]       bcnt;
  logic [1:0]       len_q;
  logic [3:0]       last_bit;
  logic [7:0]       sh;

  logic             push_vld_p1;
  logic [7:0]       push_data_p1;
  logic             ovr_set;

  // Two-flop synchroniser plus one history flop for edge detection; idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall     = rx_prev && !rx_s;
  assign div_last = bclk_mode ? DIV_LAST1 : DIV_LAST0;

  // Free-running 16x tick divider; a baud-select change restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      mode_q  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      mode_q <= bclk_mode;
      tick   <= 1'b0;
      if (mode_q != bclk_mode) begin
        div_cnt <= '0;
      end else if (div_cnt >= div_last) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign last_bit = data_bits(len_q) - 4'd1;

  // Frame FSM: start qualification, bit sampling, stop check and push request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      len_q        <= '0;
      sh           <= '0;
      push_vld_p1  <= 1'b0;
      push_data_p1 <= '0;
      frame_err    <= 1'b0;
    end else begin
      push_vld_p1 <= 1'b0;
      if (err_clr) begin
        frame_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            scnt  <= '0;
            len_q <= tlen;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == SCNT_MID) begin
              if (!rx_s) begin
                scnt  <= '0;
                bcnt  <= '0;
                sh    <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            scnt <= scnt + 4'd1;
            if (scnt == SCNT_END) begin
              sh[bcnt] <= rx_s;
              if ({1'b0, bcnt} == last_bit) begin
                state <= STOP;
              end else begin
                bcnt <= bcnt + 3'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            scnt <= scnt + 4'd1;
            if (scnt == SCNT_END) begin
              if (rx_s) begin
                push_vld_p1  <= 1'b1;
                push_data_p1 <= sh;
              end else begin
                frame_err <= 1'b1;
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: completed byte enters the FIFO ----
  rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push_vld_p1),
    .wdata (push_data_p1),
    .rd_en (rd_en),
    .rdata (rdata),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // A push into a full FIFO with no simultaneous pop loses the byte
  assign ovr_set = push_vld_p1 && rx_full && !rd_en;

  // Sticky overrun flag; a new event wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= ovr_set || (overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_recv.sv
// Self-checking bench for the UART receiver, run with a 4-clk tick divider.
module tb_recv;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk_mode;
  logic [1:0] tlen;
  logic       rx_in;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rdata;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [1:0] tl;
    logic [7:0] line;
    int         nbits;
    logic       stop;
    logic       push;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[7];

  always #5 clk = ~clk;

  recv #(
    .BAUD_DIV0  (4),
    .BAUD_DIV1  (651),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bclk_mode (bclk_mode),
    .tlen      (tlen),
    .rx_in     (rx_in),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .rdata     (rdata),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Compare the FIFO head against the scoreboard, then pop it
  task automatic pop_check(input string name);
    logic [7:0] e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard has no entry, got rdata 0x%0h", name, rdata);
    end else begin
      e = sb.pop_front();
      check({name, "_empty"}, rx_empty, 0);
      check(name, rdata, e);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int waited;
    bit seen;

    vt[0] = '{2'b11, 8'h55, 8, 1'b1, 1'b1, 8'h55};
    vt[1] = '{2'b11, 8'h38, 8, 1'b1, 1'b1, 8'h38};
    vt[2] = '{2'b00, 8'hF5, 8, 1'b1, 1'b1, 8'h15};
    vt[3] = '{2'b01, 8'hEA, 8, 1'b1, 1'b1, 8'h2A};
    vt[4] = '{2'b10, 8'hFF, 8, 1'b1, 1'b1, 8'h7F};
    vt[5] = '{2'b11, 8'hA5, 8, 1'b1, 1'b1, 8'hA5};
    vt[6] = '{2'b11, 8'h00, 8, 1'b1, 1'b1, 8'h00};

    rst       = 1'b1;
    bclk_mode = 1'b0;
    tlen      = 2'b11;
    rx_in     = 1'b1;
    rd_en     = 1'b0;
    err_clr   = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_full", rx_full, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // Single 0x38 frame, watching rx_empty fall during the stop bit
    tlen = 2'b11;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(logic'((8'h38 >> i) & 8'h01));
    rx_in = 1'b1;
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("single_empty_before_stop_sample", rx_empty, 1);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 30) begin
      @(negedge clk);
      waited++;
      if (!rx_empty) seen = 1'b1;
    end
    check("single_empty_fell", seen, 1);
    repeat (40) @(posedge clk);
    sb.push_back(8'h38);
    pop_check("single_0x38");
    check("single_empty_after_pop", rx_empty, 1);

    // Table of back-to-back frames of various lengths, drained afterwards
    for (int i = 0; i < 7; i++) begin
      tlen = vt[i].tl;
      send_frame(vt[i].line, vt[i].nbits, vt[i].stop);
      if (vt[i].push) sb.push_back(vt[i].exp);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("table_ferr", frame_err, 0);
    check("table_ovr", overrun, 0);
    for (int i = 0; i < 7; i++) pop_check($sformatf("table_%0d", i));
    check("table_empty_after", rx_empty, 1);

    // Start glitch shorter than half a bit, then a good frame
    tlen = 2'b11;
    rx_in = 1'b0;
    repeat (16) @(posedge clk);
    rx_in = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("glitch_empty", rx_empty, 1);
    check("glitch_ferr", frame_err, 0);
    send_frame(8'hA5, 8, 1'b1);
    sb.push_back(8'hA5);
    repeat (10) @(posedge clk);
    pop_check("after_glitch_0xA5");

    // Stop bit low: framing error, nothing stored, then cleared
    send_frame(8'h38, 8, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("ferr_set", frame_err, 1);
    check("ferr_empty", rx_empty, 1);
    pulse_err_clr();
    @(negedge clk);
    check("ferr_cleared", frame_err, 0);

    // Seventeen frames without reading: fill, then overrun
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 8, 1'b1);
      if (i < 16) sb.push_back(8'(i));
      if (i == 15) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("full_after_16", rx_full, 1);
        check("no_ovr_at_16", overrun, 0);
      end
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("ovr_after_17", overrun, 1);
    check("full_after_17", rx_full, 1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("fill_pop_%0d", i));
    @(negedge clk);
    check("fill_empty_after", rx_empty, 1);
    check("fill_rdata_hold", rdata, 8'h0F);
    pulse_err_clr();
    @(negedge clk);
    check("ovr_cleared", overrun, 0);

    // Reset in the middle of a frame with data buffered and an error pending
    send_frame(8'h5A, 8, 1'b1);
    send_frame(8'h11, 8, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_rst_rdata", rdata, 8'h5A);
    check("pre_rst_ferr", frame_err, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #3;
    rst   = 1'b1;
    rx_in = 1'b1;
    #1;
    check("midrst_rdata", rdata, 0);
    check("midrst_empty", rx_empty, 1);
    check("midrst_full", rx_full, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("post_rst_empty", rx_empty, 1);
    send_frame(8'hC3, 8, 1'b1);
    sb.push_back(8'hC3);
    repeat (10) @(posedge clk);
    pop_check("post_rst_0xC3");
    check("post_rst_empty_after", rx_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
